// File: rtl/vc_test_sink_pkg.sv
// vc_test_sink_pkg: shared FSM states, LFSR taps and saturating add for the val/rdy test sink
package vc_test_sink_pkg;
  typedef enum logic {DELAY, READY} state_t;
  localparam logic [31:0] LFSR_TAPS = 32'h80200003;
  function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b);
    logic [32:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[32] ? 32'hffffffff : s[31:0];
  endfunction
endpackage

// File: rtl/vc_test_sink_chan.sv
// vc_test_sink_chan: one sink channel (ports: clk reset max_delay val rdy msg load_val load_msg -> fail_pulse ovf_pulse chan_done; VC_TEST_SINK_VERBOSE_EN prints failures)
module vc_test_sink_chan
  import vc_test_sink_pkg::*;
#(
  parameter int p_msg_nbits = 1,
  parameter int p_num_msgs = 1024,
  parameter int p_ordered = 1,
  parameter logic [31:0] p_seed = 32'hdeadbeef,
  parameter int p_chan = 0
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [31:0]            max_delay,
  input  logic                   val,
  output logic                   rdy,
  input  logic [p_msg_nbits-1:0] msg,
  input  logic                   load_val,
  input  logic [p_msg_nbits-1:0] load_msg,
  output logic                   fail_pulse,
  output logic                   ovf_pulse,
  output logic                   chan_done
);
  localparam int CW = $clog2(p_num_msgs + 1);
  localparam int IW = p_num_msgs > 1 ? $clog2(p_num_msgs) : 1;
  localparam logic [CW-1:0] CAP = CW'(p_num_msgs);
  state_t state, state_n;
  logic [31:0] lfsr, count, count_n, new_count;
  logic [CW-1:0] loaded, received;
  logic [p_msg_nbits-1:0] mem [p_num_msgs];
  logic [p_num_msgs-1:0] matched;
  logic [IW-1:0] hit;
  logic fire, full, found, mis;
  assign new_count = 32'({1'b0, (reset ? p_seed : lfsr)} % ({1'b0, max_delay} + 33'd1));
  assign rdy = !reset && state == READY;
  assign fire = val && rdy;
  assign full = loaded == CAP;
  assign ovf_pulse = !reset && load_val && full;
  assign mis = received >= loaded || mem[IW'(received)] != msg;
  assign fail_pulse = fire && (p_ordered != 0 ? mis : !found);
  assign chan_done = !reset && received == loaded;
  always_comb begin
    found = 1'b0;
    hit = '0;
    for (int i = p_num_msgs - 1; i >= 0; i--)
      if (CW'(i) < loaded && !matched[i] && mem[i] == msg) begin
        found = 1'b1;
        hit = IW'(i);
      end
  end
  always_comb begin
    state_n = state == DELAY ? (count <= 32'd1 ? READY : DELAY) : fire ? (new_count == 32'd0 ? READY : DELAY) : state;
    count_n = state == DELAY ? count - 32'd1 : fire ? new_count : count;
  end
  always_ff @(posedge clk)
    if (reset) begin
      state <= new_count == 32'd0 ? READY : DELAY;
      count <= new_count;
      lfsr <= p_seed;
      loaded <= '0;
      received <= '0;
      matched <= '0;
    end else begin
      state <= state_n;
      count <= count_n;
      lfsr <= lfsr[0] ? (lfsr >> 1) ^ LFSR_TAPS : lfsr >> 1;
      if (load_val && !full) loaded <= loaded + 1'b1;
      if (fire && received != CAP) received <= received + 1'b1;
      if (fire && p_ordered == 0 && found) matched[hit] <= 1'b1;
    end
  always_ff @(posedge clk)
    if (!reset && load_val && !full) mem[IW'(loaded)] <= load_msg;
`ifdef VC_TEST_SINK_VERBOSE_EN
  always_ff @(posedge clk)
    if (!reset) begin
      if (fail_pulse && p_ordered != 0 && received >= loaded)
        $display("%0t: chan %0d idx %0d unexpected actual %h", $time, p_chan, received, msg);
      else if (fail_pulse && p_ordered != 0)
        $display("%0t: chan %0d idx %0d expected %h actual %h", $time, p_chan, received, mem[IW'(received)], msg);
      else if (fail_pulse)
        $display("%0t: chan %0d idx %0d no match actual %h", $time, p_chan, received, msg);
      if (ovf_pulse)
        $display("%0t: chan %0d idx %0d load overflow msg %h", $time, p_chan, loaded, load_msg);
    end
`endif
endmodule

// File: rtl/vc_test_multi_rand_delay_sink.sv
// vc_test_multi_rand_delay_sink: p_nchan random-backpressure sinks (ports: clk reset max_delay val rdy msg load_val load_chan load_msg -> num_failed chan_done done; VC_TEST_SINK_VERBOSE_EN prints failures)
module vc_test_multi_rand_delay_sink
  import vc_test_sink_pkg::*;
#(
  parameter int p_msg_nbits = 1,
  parameter int p_num_msgs = 1024,
  parameter int p_nchan = 2,
  parameter int p_ordered = 1,
  parameter logic [31:0] p_seed = 32'hdeadbeef
) (
  input  logic                                       clk,
  input  logic                                       reset,
  input  logic [31:0]                                max_delay,
  input  logic [p_nchan-1:0]                         val,
  output logic [p_nchan-1:0]                         rdy,
  input  logic [p_nchan*p_msg_nbits-1:0]             msg,
  input  logic                                       load_val,
  input  logic [$clog2(p_nchan > 1 ? p_nchan : 2)-1:0] load_chan,
  input  logic [p_msg_nbits-1:0]                     load_msg,
  output logic [31:0]                                num_failed,
  output logic [p_nchan-1:0]                         chan_done,
  output logic                                       done
);
  localparam int LCW = $bits(load_chan);
  logic [p_nchan-1:0] fails, ovfs;
  logic [31:0] inc;
  for (genvar g = 0; g < p_nchan; g++) begin : g_chan
    vc_test_sink_chan #(
      .p_msg_nbits(p_msg_nbits),
      .p_num_msgs(p_num_msgs),
      .p_ordered(p_ordered),
      .p_seed(p_seed ^ 32'(g)),
      .p_chan(g)
    ) u_chan (
      .clk(clk),
      .reset(reset),
      .max_delay(max_delay),
      .val(val[g]),
      .rdy(rdy[g]),
      .msg(msg[g*p_msg_nbits +: p_msg_nbits]),
      .load_val(load_val && load_chan == LCW'(g)),
      .load_msg(load_msg),
      .fail_pulse(fails[g]),
      .ovf_pulse(ovfs[g]),
      .chan_done(chan_done[g])
    );
  end
  always_comb begin
    inc = '0;
    for (int c = 0; c < p_nchan; c++) inc = inc + 32'(fails[c]) + 32'(ovfs[c]);
  end
  always_ff @(posedge clk)
    if (reset) num_failed <= '0;
    else num_failed <= sat_add(num_failed, inc);
  assign done = &chan_done;
endmodule

// File: tb/tb_vc_test_multi_rand_delay_sink.sv
// tb_vc_test_multi_rand_delay_sink: scoreboard bench for ordered 4-channel and unordered 1-channel sinks
module tb_vc_test_multi_rand_delay_sink;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;
  logic [31:0] a_md = '0, b_md = '0;
  logic [3:0] a_val = '0, a_rdy, a_cd;
  logic [31:0] a_msg = '0, a_nf, b_nf;
  logic a_lv = 1'b0, a_done;
  logic [1:0] a_lc = '0;
  logic [7:0] a_lm = '0, b_msg = '0, b_lm = '0;
  logic b_val = 1'b0, b_rdy, b_lv = 1'b0, b_lc = 1'b0, b_cd, b_done;
  vc_test_multi_rand_delay_sink #(.p_msg_nbits(8), .p_num_msgs(8), .p_nchan(4), .p_ordered(1)) u_a (
    .clk(clk), .reset(reset), .max_delay(a_md), .val(a_val), .rdy(a_rdy), .msg(a_msg),
    .load_val(a_lv), .load_chan(a_lc), .load_msg(a_lm), .num_failed(a_nf), .chan_done(a_cd), .done(a_done));
  vc_test_multi_rand_delay_sink #(.p_msg_nbits(8), .p_num_msgs(4), .p_nchan(1), .p_ordered(0)) u_b (
    .clk(clk), .reset(reset), .max_delay(b_md), .val(b_val), .rdy(b_rdy), .msg(b_msg),
    .load_val(b_lv), .load_chan(b_lc), .load_msg(b_lm), .num_failed(b_nf), .chan_done(b_cd), .done(b_done));
  int passed = 0, total = 0;
  logic [7:0] a_q [4][$];
  logic [7:0] b_q [$];
  int a_ld [4], a_rc [4];
  int a_fail, b_ld, b_rc, b_fail;
  int g1 [100], g2 [100];
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic clr_model();
    for (int c = 0; c < 4; c++) begin
      a_q[c].delete();
      a_ld[c] = 0;
      a_rc[c] = 0;
    end
    b_q.delete();
    a_fail = 0;
    b_ld = 0;
    b_rc = 0;
    b_fail = 0;
  endtask
  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    clr_model();
    #1;
  endtask
  function automatic logic [3:0] exp_cd();
    logic [3:0] r;
    for (int c = 0; c < 4; c++) r[c] = a_rc[c] == a_ld[c];
    return r;
  endfunction
  function automatic void a_model(input int c, input logic [7:0] m);
    if (a_q[c].size() == 0) a_fail++;
    else if (a_q[c].pop_front() != m) a_fail++;
    if (a_rc[c] < 8) a_rc[c]++;
  endfunction
  function automatic void b_model(input logic [7:0] m);
    int idx = -1;
    for (int i = 0; i < b_q.size(); i++) if (idx < 0 && b_q[i] == m) idx = i;
    if (idx < 0) b_fail++;
    else b_q.delete(idx);
    if (b_rc < 4) b_rc++;
  endfunction
  task automatic load_a(input int c, input logic [7:0] m);
    a_lv = 1'b1;
    a_lc = 2'(c);
    a_lm = m;
    tick();
    a_lv = 1'b0;
    if (a_ld[c] == 8) a_fail++;
    else begin
      a_q[c].push_back(m);
      a_ld[c]++;
    end
  endtask
  task automatic load_b(input logic [7:0] m);
    b_lv = 1'b1;
    b_lm = m;
    tick();
    b_lv = 1'b0;
    if (b_ld == 4) b_fail++;
    else begin
      b_q.push_back(m);
      b_ld++;
    end
  endtask
  task automatic send_a(input logic [3:0] mask, input logic [31:0] m, output int cyc);
    logic [3:0] pend, f;
    pend = mask;
    a_msg = m;
    a_val = pend;
    cyc = 0;
    while (pend != 0 && cyc < 40) begin
      @(negedge clk);
      f = pend & a_rdy;
      for (int c = 0; c < 4; c++) if (f[c]) a_model(c, m[c*8 +: 8]);
      tick();
      pend = pend & ~f;
      a_val = pend;
      cyc++;
    end
    if (pend != 0) check("send_a_timeout", 32'(pend), 32'd0);
  endtask
  task automatic send_b(input logic [7:0] m);
    bit fired = 1'b0;
    b_msg = m;
    b_val = 1'b1;
    for (int k = 0; k < 40 && !fired; k++) begin
      @(negedge clk);
      fired = b_rdy;
      tick();
    end
    b_val = 1'b0;
    if (fired) b_model(m);
    else check("send_b_timeout", 32'(fired), 32'd1);
  endtask
  task automatic check_a(input string tag);
    check({tag, "_nf"}, a_nf, 32'(a_fail));
    check({tag, "_cd"}, 32'(a_cd), 32'(exp_cd()));
    check({tag, "_done"}, 32'(a_done), 32'(&exp_cd()));
  endtask
  task automatic run_gaps(input bit second);
    int n;
    for (int k = 0; k < 100; k++) begin
      n = 0;
      @(negedge clk);
      while (!a_rdy[1] && n < 10) begin
        n++;
        @(negedge clk);
      end
      if (a_rdy[1]) a_model(1, 8'h00);
      if (second) g2[k] = n;
      else g1[k] = n;
      tick();
    end
  endtask
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    int cyc, tot, bad, oor, nf0;
    logic [3:0] seen;
    clr_model();
    tick();
    tick();
    check("rst_rdy", 32'(a_rdy), 32'd0);
    check("rst_cd", 32'(a_cd), 32'd0);
    check("rst_done", 32'(a_done), 32'd0);
    reset = 1'b0;
    #1;
    check("post_rst_rdy", 32'(a_rdy), 32'hf);
    check("post_rst_b_rdy", 32'(b_rdy), 32'd1);
    check_a("post_rst");
    load_b(8'ha);
    load_b(8'hb);
    load_b(8'ha);
    check("unord_pre_done", 32'(b_done), 32'd0);
    send_b(8'ha);
    send_b(8'ha);
    send_b(8'hb);
    check("unord_nf", b_nf, 32'(b_fail));
    check("unord_done", 32'(b_done), 32'(b_rc == b_ld));
    send_b(8'ha);
    check("unord_extra_nf", b_nf, 32'(b_fail));
    check("unord_extra_done", 32'(b_done), 32'(b_rc == b_ld));
    load_a(0, 8'h1);
    load_a(0, 8'h2);
    load_a(0, 8'h3);
    check_a("ord_loaded");
    tot = 0;
    for (int k = 1; k <= 3; k++) begin
      send_a(4'b0001, 32'(k), cyc);
      tot += cyc;
    end
    check("b2b_cycles", 32'(tot), 32'd3);
    check_a("ord_b2b");
    load_a(0, 8'h1);
    load_a(0, 8'h2);
    load_a(0, 8'h3);
    send_a(4'b0001, 32'h1, cyc);
    send_a(4'b0001, 32'h5, cyc);
    send_a(4'b0001, 32'h3, cyc);
    check_a("ord_mis");
    send_a(4'b0001, 32'h9, cyc);
    check_a("ord_unexp");
    a_md = 32'd2;
    do_reset();
    check_a("multi_rst");
    for (int k = 0; k < 5; k++)
      for (int c = 0; c < 4; c++) if (c != 2) load_a(c, 8'(c * 16 + k));
    check_a("multi_loaded");
    for (int k = 0; k < 5; k++) begin
      if (k == 4) check("multi_not_done", 32'(a_done), 32'd0);
      send_a(4'b1011, {8'(48 + k), 8'h00, 8'(16 + k), 8'(k)}, cyc);
    end
    check_a("multi_sent");
    load_a(0, 8'h11);
    load_a(3, 8'h11);
    a_md = 32'd0;
    for (int k = 0; k < 10 && !(a_rdy[0] && a_rdy[3]); k++) tick();
    nf0 = int'(a_nf);
    send_a(4'b1001, {8'h22, 8'h00, 8'h00, 8'h22}, cyc);
    check("dual_cycles", 32'(cyc), 32'd1);
    check("dual_delta", a_nf - 32'(nf0), 32'd2);
    check_a("dual");
    a_md = 32'd3;
    do_reset();
    a_val = 4'b0010;
    a_msg = '0;
    run_gaps(1'b0);
    check("gap_nf", a_nf, 32'(a_fail));
    reset = 1'b1;
    @(negedge clk);
    check("mid_rst_rdy", 32'(a_rdy), 32'd0);
    tick();
    reset = 1'b0;
    clr_model();
    check("mid_rst_nf", a_nf, 32'd0);
    run_gaps(1'b1);
    a_val = '0;
    bad = 0;
    oor = 0;
    seen = '0;
    for (int k = 0; k < 100; k++) begin
      if (g1[k] != g2[k]) bad++;
      if (g1[k] > 3) oor++;
      else seen[g1[k]] = 1'b1;
    end
    check("gap_repeat", 32'(bad), 32'd0);
    check("gap_range", 32'(oor), 32'd0);
    check("gap_cover", 32'(seen), 32'hf);
    check("gap2_nf", a_nf, 32'(a_fail));
    a_md = 32'd0;
    do_reset();
    for (int k = 1; k <= 5; k++) load_b(8'(k));
    check("ovf_nf", b_nf, 32'(b_fail));
    for (int k = 1; k <= 4; k++) send_b(8'(k));
    check("ovf_done", 32'(b_done), 32'(b_rc == b_ld));
    check("ovf_final_nf", b_nf, 32'(b_fail));
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
